// File: rtl/cell_id_tracker_pkg.sv
// Shared types and constants for the cell ID tracker and SSS detector users.
package cell_id_tracker_pkg;

  localparam int unsigned N_ID_W   = 10;
  localparam int unsigned N_ID_MAX = 1007;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned STATE_W  = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_SEARCH  = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  function automatic logic n_id_legal(input logic [N_ID_W-1:0] id);
    return id <= N_ID_W'(N_ID_MAX);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/cell_id_tracker_if.sv
// Detection input strobes and tracker status outputs between SSS detector and PBCH side.
interface cell_id_tracker_if;
  import cell_id_tracker_pkg::*;

  logic                SSB_start_i;
  logic [N_ID_W-1:0]   N_id_i;
  logic                N_id_valid_i;
  logic                locked_o;
  logic [N_ID_W-1:0]   N_id_o;
  logic                N_id_valid_o;
  logic                lock_lost_o;
  logic [STATE_W-1:0]  state_o;
  logic [CNT_W-1:0]    miss_count_o;

  modport master (
    output SSB_start_i, N_id_i, N_id_valid_i,
    input  locked_o, N_id_o, N_id_valid_o, lock_lost_o, state_o, miss_count_o
  );

  modport slave (
    input  SSB_start_i, N_id_i, N_id_valid_i,
    output locked_o, N_id_o, N_id_valid_o, lock_lost_o, state_o, miss_count_o
  );

endinterface

// File: rtl/cell_id_tracker_ssb_window_monitor.sv
// Tracks detections within one SSB period and grades the period when SSB_start closes it.
module cell_id_tracker_ssb_window_monitor (
  input  logic clk_i,
  input  logic reset_i,
  input  logic ssb_start_i,
  input  logic det_i,
  input  logic mismatch_i,
  input  logic clear_i,
  output logic win_hit_o,
  output logic close_good_c,
  output logic close_bad_c
);

  logic win_hit_q, win_hit_d;
  logic win_bad_q, win_bad_d;
  logic hit_now_c, bad_now_c;

  // A detection arriving with SSB_start still belongs to the window being closed.
  always_comb begin
    hit_now_c    = win_hit_q | det_i;
    bad_now_c    = win_bad_q | mismatch_i;
    close_good_c = ssb_start_i & hit_now_c & ~bad_now_c;
    close_bad_c  = ssb_start_i & ~(hit_now_c & ~bad_now_c);
    win_hit_d    = hit_now_c;
    win_bad_d    = bad_now_c;
    if (ssb_start_i || clear_i) begin
      win_hit_d = 1'b0;
      win_bad_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      win_hit_q <= 1'b0;
      win_bad_q <= 1'b0;
    end else begin
      win_hit_q <= win_hit_d;
      win_bad_q <= win_bad_d;
    end
  end

  assign win_hit_o = win_hit_q;

endmodule

// File: rtl/cell_id_tracker.sv
// Confirms a cell ID over consecutive SSB detections and tracks lock loss over bad SSB periods.
module cell_id_tracker
  import cell_id_tracker_pkg::*;
#(
  parameter int unsigned CONFIRM_COUNT = 3,
  parameter int unsigned LOSS_COUNT    = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  cell_id_tracker_if.slave   bus
);

  state_e              state_q;
  logic [N_ID_W-1:0]   cand_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    miss_q;
  logic                locked_q;
  logic [N_ID_W-1:0]   n_id_q;
  logic                n_id_valid_q;
  logic                lock_lost_q;

  logic                det_c, match_c, mismatch_c;
  logic [CNT_W:0]      cnt_inc_c, miss_inc_c;
  logic                confirm_done_c, loss_hit_c, lock_now_c;
  logic                win_hit_c, close_good_c, close_bad_c;

  // Out-of-range IDs are treated as if no detection arrived.
  always_comb begin
    det_c          = bus.N_id_valid_i & n_id_legal(bus.N_id_i);
    match_c        = det_c & (bus.N_id_i == cand_q);
    mismatch_c     = det_c & (bus.N_id_i != cand_q);
    cnt_inc_c      = {1'b0, cnt_q} + (CNT_W+1)'(1);
    miss_inc_c     = {1'b0, miss_q} + (CNT_W+1)'(1);
    confirm_done_c = (cnt_inc_c == (CNT_W+1)'(CONFIRM_COUNT));
    loss_hit_c     = (miss_inc_c == (CNT_W+1)'(LOSS_COUNT));
    lock_now_c     = ((state_q == ST_SEARCH) && det_c && (CONFIRM_COUNT == 1)) ||
                     ((state_q == ST_CONFIRM) && match_c && confirm_done_c);
  end

  cell_id_tracker_ssb_window_monitor u_ssb_window_monitor (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .ssb_start_i  (bus.SSB_start_i),
    .det_i        (det_c),
    .mismatch_i   (mismatch_c),
    .clear_i      (lock_now_c),
    .win_hit_o    (win_hit_c),
    .close_good_c (close_good_c),
    .close_bad_c  (close_bad_c)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= ST_SEARCH;
      cand_q       <= '0;
      cnt_q        <= '0;
      miss_q       <= '0;
      locked_q     <= 1'b0;
      n_id_q       <= '0;
      n_id_valid_q <= 1'b0;
      lock_lost_q  <= 1'b0;
    end else begin
      n_id_valid_q <= 1'b0;
      lock_lost_q  <= 1'b0;
      case (state_q)
        ST_SEARCH: begin
          if (det_c) begin
            cand_q <= bus.N_id_i;
            cnt_q  <= CNT_W'(1);
            if (lock_now_c) begin
              state_q      <= ST_LOCKED;
              locked_q     <= 1'b1;
              n_id_q       <= bus.N_id_i;
              n_id_valid_q <= 1'b1;
              miss_q       <= '0;
            end else begin
              state_q <= ST_CONFIRM;
            end
          end
        end
        ST_CONFIRM: begin
          if (match_c) begin
            cnt_q <= cnt_inc_c[CNT_W-1:0];
            if (lock_now_c) begin
              state_q      <= ST_LOCKED;
              locked_q     <= 1'b1;
              n_id_q       <= cand_q;
              n_id_valid_q <= 1'b1;
              miss_q       <= '0;
            end
          end else if (mismatch_c) begin
            cand_q <= bus.N_id_i;
            cnt_q  <= CNT_W'(1);
          end else if (bus.SSB_start_i && !win_hit_c) begin
            state_q <= ST_SEARCH;
            cnt_q   <= '0;
          end
        end
        ST_LOCKED: begin
          // A losing window suppresses any same-cycle match pulse.
          if (match_c && !(close_bad_c && loss_hit_c)) n_id_valid_q <= 1'b1;
          if (close_good_c) begin
            miss_q <= '0;
          end else if (close_bad_c) begin
            if (loss_hit_c) begin
              state_q     <= ST_SEARCH;
              lock_lost_q <= 1'b1;
              locked_q    <= 1'b0;
              n_id_q      <= '0;
              miss_q      <= '0;
              cnt_q       <= '0;
            end else begin
              miss_q <= sat_inc(miss_q);
            end
          end
        end
        default: state_q <= ST_SEARCH;
      endcase
    end
  end

  assign bus.locked_o     = locked_q;
  assign bus.N_id_o       = n_id_q;
  assign bus.N_id_valid_o = n_id_valid_q;
  assign bus.lock_lost_o  = lock_lost_q;
  assign bus.state_o      = state_q;
  assign bus.miss_count_o = miss_q;

endmodule

// File: tb/tb_cell_id_tracker.sv
// Bench for cell_id_tracker: directed vector table, corner sequences, and random traffic
// against a window-list reference model for a CONFIRM=3/LOSS=4 and a CONFIRM=1/LOSS=2 build.
module tb_cell_id_tracker;

  typedef struct packed {
    logic       locked;
    logic [9:0] id;
    logic       nv;
    logic       lost;
    logic [1:0] st;
    logic [3:0] miss;
  } outs_t;

  typedef struct {
    bit    ssb;
    bit    v;
    int    id;
    outs_t exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       ssb, vld;
  logic [9:0] nid;
  int         n_cmp = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  cell_id_tracker_if if_a ();
  cell_id_tracker_if if_b ();

  assign if_a.SSB_start_i  = ssb;
  assign if_a.N_id_valid_i = vld;
  assign if_a.N_id_i       = nid;
  assign if_b.SSB_start_i  = ssb;
  assign if_b.N_id_valid_i = vld;
  assign if_b.N_id_i       = nid;

  cell_id_tracker #(.CONFIRM_COUNT(3), .LOSS_COUNT(4)) dut_a (
    .clk_i(clk), .reset_i(rst), .bus(if_a.slave));
  cell_id_tracker #(.CONFIRM_COUNT(1), .LOSS_COUNT(2)) dut_b (
    .clk_i(clk), .reset_i(rst), .bus(if_b.slave));

  outs_t oa, ob;
  assign oa = {if_a.locked_o, if_a.N_id_o, if_a.N_id_valid_o, if_a.lock_lost_o,
               if_a.state_o, if_a.miss_count_o};
  assign ob = {if_b.locked_o, if_b.N_id_o, if_b.N_id_valid_o, if_b.lock_lost_o,
               if_b.state_o, if_b.miss_count_o};

  // Reference model: mode, candidate streak, and per-window detection tallies.
  int    m_conf [2] = '{3, 1};
  int    m_loss [2] = '{4, 2};
  int    m_mode [2], m_cand [2], m_streak [2], m_miss [2], m_lid [2];
  int    m_wn [2], m_wm [2];
  outs_t m_out [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_cand[k] = 0; m_streak[k] = 0; m_miss[k] = 0;
      m_lid[k] = 0; m_wn[k] = 0; m_wm[k] = 0; m_out[k] = '0;
    end
  endtask

  task automatic model_lock(input int k, inout outs_t o);
    m_mode[k] = 2; m_lid[k] = m_cand[k]; m_miss[k] = 0;
    m_wn[k] = 0; m_wm[k] = 0;
    o.locked = 1'b1; o.id = 10'(m_cand[k]); o.nv = 1'b1;
  endtask

  task automatic model_step(input int k, input bit s, input bit v, input int id);
    outs_t o;
    bit    det;
    bit    good;
    det = v && (id <= 1007);
    o = m_out[k];
    o.nv = 1'b0;
    o.lost = 1'b0;
    case (m_mode[k])
      0: begin
        if (det) begin
          m_cand[k] = id; m_streak[k] = 1; m_wn[k]++;
          if (m_streak[k] >= m_conf[k]) model_lock(k, o);
          else m_mode[k] = 1;
        end
        if (s) begin m_wn[k] = 0; m_wm[k] = 0; end
      end
      1: begin
        if (det) begin
          m_wn[k]++;
          if (id == m_cand[k]) begin
            m_streak[k]++;
            if (m_streak[k] == m_conf[k]) model_lock(k, o);
          end else begin
            m_cand[k] = id; m_streak[k] = 1;
          end
        end
        if (s && m_mode[k] == 1) begin
          if (m_wn[k] == 0) m_mode[k] = 0;
          m_wn[k] = 0; m_wm[k] = 0;
        end
      end
      default: begin
        if (det) begin
          m_wn[k]++;
          if (id == m_lid[k]) begin m_wm[k]++; o.nv = 1'b1; end
        end
        if (s) begin
          good = (m_wn[k] > 0) && (m_wm[k] == m_wn[k]);
          if (good) m_miss[k] = 0;
          else if (m_miss[k] + 1 == m_loss[k]) begin
            m_mode[k] = 0; m_miss[k] = 0;
            o.locked = 1'b0; o.id = '0; o.lost = 1'b1; o.nv = 1'b0;
          end else if (m_miss[k] < 15) m_miss[k]++;
          m_wn[k] = 0; m_wm[k] = 0;
        end
      end
    endcase
    o.st = 2'(m_mode[k]);
    o.miss = 4'(m_miss[k]);
    m_out[k] = o;
  endtask

  task automatic cycle(input bit s, input bit v, input int id);
    ssb = s; vld = v; nid = 10'(id);
    @(posedge clk);
    #1;
    model_step(0, s, v, id);
    model_step(1, s, v, id);
    ssb = 1'b0; vld = 1'b0; nid = '0;
  endtask

  task automatic check(input string name, input outs_t act, input outs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got lk=%0b id=%0d nv=%0b lost=%0b st=%0d miss=%0d, want lk=%0b id=%0d nv=%0b lost=%0b st=%0d miss=%0d",
               name, act.locked, act.id, act.nv, act.lost, act.st, act.miss,
               exp.locked, exp.id, exp.nv, exp.lost, exp.st, exp.miss);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; ssb = 1'b0; vld = 1'b0; nid = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic outs_t mk_o(bit lk, int eid, bit nv, bit lost, int st, int miss);
    return {lk, 10'(eid), nv, lost, 2'(st), 4'(miss)};
  endfunction

  function automatic vec_t mk(bit s, bit v, int id, bit lk, int eid, bit nv, bit lost,
                              int st, int miss);
    vec_t r;
    r.ssb = s; r.v = v; r.id = id;
    r.exp = mk_o(lk, eid, nv, lost, st, miss);
    return r;
  endfunction

  vec_t tab[$];

  initial begin
    // ssb v id | locked id nv lost state miss   (CONFIRM=3, LOSS=4 build)
    tab.push_back(mk(0,1,500,  0,0,0,0,1,0));
    tab.push_back(mk(1,0,0,    0,0,0,0,1,0));
    tab.push_back(mk(0,1,500,  0,0,0,0,1,0));
    tab.push_back(mk(1,0,0,    0,0,0,0,1,0));
    tab.push_back(mk(0,1,500,  1,500,1,0,2,0));
    tab.push_back(mk(0,0,0,    1,500,0,0,2,0));
    tab.push_back(mk(1,0,0,    1,500,0,0,2,1));
    tab.push_back(mk(1,0,0,    1,500,0,0,2,2));
    tab.push_back(mk(1,0,0,    1,500,0,0,2,3));
    tab.push_back(mk(1,0,0,    0,0,0,1,0,0));
    tab.push_back(mk(0,0,0,    0,0,0,0,0,0));
    tab.push_back(mk(0,1,500,  0,0,0,0,1,0));
    tab.push_back(mk(0,1,500,  0,0,0,0,1,0));
    tab.push_back(mk(0,1,77,   0,0,0,0,1,0));
    tab.push_back(mk(0,1,77,   0,0,0,0,1,0));
    tab.push_back(mk(0,1,77,   1,77,1,0,2,0));
    tab.push_back(mk(1,0,0,    1,77,0,0,2,1));
    tab.push_back(mk(1,0,0,    1,77,0,0,2,2));
    tab.push_back(mk(1,0,0,    1,77,0,0,2,3));
    tab.push_back(mk(0,1,77,   1,77,1,0,2,3));
    tab.push_back(mk(1,0,0,    1,77,0,0,2,0));
    tab.push_back(mk(0,1,77,   1,77,1,0,2,0));
    tab.push_back(mk(0,1,78,   1,77,0,0,2,0));
    tab.push_back(mk(1,0,0,    1,77,0,0,2,1));
    tab.push_back(mk(1,0,0,    1,77,0,0,2,2));
    tab.push_back(mk(1,0,0,    1,77,0,0,2,3));
    tab.push_back(mk(1,1,77,   1,77,1,0,2,0));
    tab.push_back(mk(1,0,0,    1,77,0,0,2,1));
    tab.push_back(mk(1,0,0,    1,77,0,0,2,2));
    tab.push_back(mk(1,0,0,    1,77,0,0,2,3));
    tab.push_back(mk(1,1,78,   0,0,0,1,0,0));
    tab.push_back(mk(0,1,1010, 0,0,0,0,0,0));
    tab.push_back(mk(1,1,1008, 0,0,0,0,0,0));
    tab.push_back(mk(0,1,300,  0,0,0,0,1,0));
    tab.push_back(mk(1,0,0,    0,0,0,0,1,0));
    tab.push_back(mk(1,0,0,    0,0,0,0,0,0));
    tab.push_back(mk(0,1,1023, 0,0,0,0,0,0));

    do_reset();
    check("reset_a", oa, '0);
    check("reset_b", ob, '0);

    foreach (tab[i]) begin
      cycle(tab[i].ssb, tab[i].v, tab[i].id);
      check($sformatf("vec%0d", i), oa, tab[i].exp);
    end

    // Asynchronous reset in the middle of a lock.
    do_reset();
    cycle(0, 1, 5);
    cycle(0, 1, 5);
    cycle(0, 1, 5);
    check("pre_rst_lock", oa, mk_o(1, 5, 1, 0, 2, 0));
    cycle(0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_a", oa, '0);
    check("rst_async_b", ob, '0);
    @(posedge clk);
    #1;
    check("rst_held", oa, '0);
    rst = 1'b0;
    model_reset();
    cycle(0, 0, 0);
    check("rst_after", oa, '0);

    // Single-detection lock build with illegal IDs and LOSS_COUNT=2.
    do_reset();
    cycle(0, 1, 1010);
    check("b_ignore_1010", ob, '0);
    cycle(0, 1, 1007);
    check("b_lock_1007", ob, mk_o(1, 1007, 1, 0, 2, 0));
    cycle(0, 1, 1010);
    check("b_locked_1010", ob, mk_o(1, 1007, 0, 0, 2, 0));
    cycle(0, 1, 1007);
    check("b_match", ob, mk_o(1, 1007, 1, 0, 2, 0));
    cycle(1, 0, 0);
    check("b_good_win", ob, mk_o(1, 1007, 0, 0, 2, 0));
    cycle(1, 0, 0);
    check("b_miss1", ob, mk_o(1, 1007, 0, 0, 2, 1));
    cycle(1, 0, 0);
    check("b_lost", ob, mk_o(0, 0, 0, 1, 0, 0));

    // Random traffic against the reference model for both builds.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      bit s, v;
      int id;
      s = ((c / 500) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      v = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 7))
        0, 1, 2, 3: id = 12;
        4:          id = 13;
        5:          id = 1007;
        6:          id = 1008 + int'($urandom_range(0, 15));
        default:    id = int'($urandom_range(0, 1007));
      endcase
      cycle(s, v, id);
      check($sformatf("rand_a%0d", c), oa, m_out[0]);
      check($sformatf("rand_b%0d", c), ob, m_out[1]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cell_id_tracker.md
# cell_id_tracker

Downstream consumer of the SSS detector output in the PSS→frame_sync→FFT_demod→SSS chain. Accepts per-SSB N_id detections plus the frame_sync SSB_start strobe, confirms a cell after CONFIRM_COUNT consecutive matching detections, and declares lock loss after LOSS_COUNT consecutive bad SSB periods. Provides a stable, registered cell identity and lock status for the PBCH decoder and control software.

## Interface
- CONFIRM_COUNT, 3: consecutive matching detections required to lock; legal 1..15
- LOSS_COUNT, 4: consecutive missed/mismatched SSB periods that drop lock; legal 1..15
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous, active-high reset
- SSB_start_i  in  1  one-cycle pulse from frame_sync at each SSB start; closes the current detection window and opens a new one
- N_id_i  in  10  detected cell ID, 0..1007
- N_id_valid_i  in  1  one-cycle qualifier for N_id_i (SSS detector m_axis tvalid)
- locked_o  out  1  high while in LOCKED
- N_id_o  out  10  locked cell ID; held while locked, 0 otherwise
- N_id_valid_o  out  1  one-cycle pulse on lock acquisition and on each matching detection while locked
- lock_lost_o  out  1  one-cycle pulse on LOCKED→SEARCH
- state_o  out  2  debug: current state encoding
- miss_count_o  out  4  debug: current consecutive-bad-period count

## Operation
- States: SEARCH (0), CONFIRM (1), LOCKED (2). Encoding 3 unused; if reached, go to SEARCH next cycle.
- Registers: cand (10b), cnt (4b confirm counter), miss (4b), win_hit (1b: a detection has arrived in the current window), win_bad (1b: a mismatch arrived in the current window).
- N_id_i values >1007 with valid are ignored entirely (no state effect).
- SEARCH: on valid: cand<=N_id_i, cnt<=1; if CONFIRM_COUNT==1 go LOCKED (lock actions), else go CONFIRM. SSB_start ignored.
- CONFIRM: valid with N_id_i==cand: cnt++; when cnt+1==CONFIRM_COUNT go LOCKED. Valid mismatch: cand<=N_id_i, cnt<=1, stay. SSB_start with win_hit==0: go SEARCH, cnt<=0.
- Lock actions: N_id_o<=cand, locked_o<=1, N_id_valid_o pulse, miss<=0, win flags cleared.
- LOCKED: valid match: N_id_valid_o pulse, win_hit<=1. Valid mismatch: win_bad<=1, no output pulse, N_id_o unchanged. On SSB_start: window is good iff win_hit && !win_bad; good → miss<=0; bad → miss++ ; if miss+1==LOSS_COUNT → SEARCH, lock_lost_o pulse, locked_o<=0, N_id_o<=0, miss<=0.
- Simultaneous SSB_start and N_id_valid in same cycle: the detection belongs to the window being closed (evaluated first), then flags clear for the new window.
- Multiple detections in one window: each evaluated; any mismatch marks window bad.
- miss saturates at 15 (unreachable with legal LOSS_COUNT, still required).

## Timing
- All outputs registered; response appears the cycle after the triggering input edge (latency 1).
- Reset (async assert, sync to clk_i deassert by upstream): state SEARCH, all outputs 0, all internal registers 0.
- Reset mid-lock: outputs drop to 0 immediately (asynchronously); no lock_lost_o pulse.
- N_id_valid_o and lock_lost_o never both high; N_id_valid_o only when locked_o is high in the same cycle.
- No backpressure; inputs are strobes accepted every cycle.

## Structure
- Package cell_id_tracker_pkg: state enum (SEARCH/CONFIRM/LOCKED), N_ID_W=10, N_ID_MAX=1007, shared with SSS_detector users.
- One natural sub-module: ssb_window_monitor (win_hit/win_bad flags, window-close evaluation pulse good/bad on SSB_start), instantiated once; FSM and counters in top.

## Test plan
- Reset, then N_id 500 valid three times across three SSB periods → locked_o=1, N_id_o=500, N_id_valid_o pulse one cycle after third detection.
- CONFIRM with sequence 500,500,77,77,77 → locks on 77, never on 500.
- Locked on 500, four SSB_starts with no detection → lock_lost_o pulse on fourth, locked_o=0, N_id_o=0; three misses then a match → stays locked, miss_count_o back to 0.
- Locked on 500, window containing 500 then 501 → counted bad (miss_count_o=1), N_id_o stays 500, one N_id_valid_o pulse only.
- N_id_valid and SSB_start same cycle with matching ID while locked, miss=3 → window good, no loss; CONFIRM_COUNT=1 build: single detection of 1007 locks immediately; detection of 1010 ignored.
- Assert reset_i mid-LOCKED → all outputs 0 same cycle, state_o=0, no lock_lost_o.
